fft_stage_feeder: RTL and testbench

Operand sequencer that sits directly upstream of the radix-2 butterfly in one stage of the N-point DIT FFT. It collects one frame of N complex samples from a ready/valid stream into a local buffer, then issues N/2 `{even, odd, twiddle}` operand triples on consecutive enabled cycles. Each triple drives the butterfly's `i_i_even`, `i_i_odd` and `i_i_twi` inputs. `STAGE` and `BITREV` select the pairing pattern, so the same block serves every stage.

---
 rtl/fft_stage_feeder_pkg.sv | 52 +++++
 rtl/fft_stage_feeder_if.sv | 16 +
 rtl/fft_stage_feeder_twiddle_rom.sv | 17 +
 rtl/fft_stage_feeder.sv | 130 +++++++++++++
 tb/tb_fft_stage_feeder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stage_feeder_pkg.sv
// Shared types, Q1.15 constants and elaboration-time helpers for the FFT stage feeder.
package fft_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [0:1][DATA_W-1:0] cplx_t;

    localparam logic signed [DATA_W-1:0] Q_ONE_SAT   = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MINUS_ONE = 16'sh8000;

    // Fixed-point scale used only while building the twiddle table.
    localparam int     TRIG_FRAC = 28;
    localparam longint TRIG_ONE  = 64'sd1 <<< TRIG_FRAC;
    localparam longint PI_FIX    = 64'sd843314857;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] v;
        logic [31:0] r;
        v = idx;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

    // Taylor-series cos/sin of 2*pi*t/n, rounded to Q1.15 and saturated.
    function automatic logic signed [DATA_W-1:0] q15_trig(input int t, input int n,
                                                          input bit is_sin, input bit negate);
        longint x, x2, term, acc, r;
        x    = (PI_FIX * 2 * longint'(t)) / longint'(n);
        x2   = (x * x) >>> TRIG_FRAC;
        term = is_sin ? x : TRIG_ONE;
        acc  = term;
        for (int k = 1; k <= 14; k++) begin
            if (is_sin) term = -((term * x2) >>> TRIG_FRAC) / longint'((2 * k) * (2 * k + 1));
            else        term = -((term * x2) >>> TRIG_FRAC) / longint'((2 * k - 1) * (2 * k));
            acc = acc + term;
        end
        if (negate) acc = -acc;
        r = (acc + (TRIG_ONE >>> DATA_W)) >>> (TRIG_FRAC - (DATA_W - 1));
        if (r > longint'(Q_ONE_SAT))   r = longint'(Q_ONE_SAT);
        if (r < longint'(Q_MINUS_ONE)) r = longint'(Q_MINUS_ONE);
        return DATA_W'(r);
    endfunction

endpackage

// File: rtl/fft_stage_feeder_if.sv
// Sample-in / operand-out bundle between the stream source, the feeder and the butterfly.
interface fft_stage_feeder_if;
    logic          i_valid;
    fft_pkg::cplx_t i_i_data;
    logic          o_ready;
    logic          o_valid;
    fft_pkg::cplx_t o_o_even;
    fft_pkg::cplx_t o_o_odd;
    fft_pkg::cplx_t o_o_twi;
    logic          o_last;

    modport slave (input i_valid, i_i_data,
                   output o_ready, o_valid, o_o_even, o_o_odd, o_o_twi, o_last);
    modport master (output i_valid, i_i_data,
                    input o_ready, o_valid, o_o_even, o_o_odd, o_o_twi, o_last);
endinterface

// File: rtl/fft_stage_feeder_twiddle_rom.sv
// Combinational W_N^t lookup for t in 0..N/2-1; table values fixed at elaboration.
module twiddle_rom import fft_pkg::*; #(
    parameter int N = 8
) (
    input  logic [addr_w(N)-2:0] t_i,
    output cplx_t                twi_o
);
    cplx_t rom_w [N/2];

    for (genvar t = 0; t < N/2; t++) begin : g_rom
        localparam logic signed [DATA_W-1:0] RE = q15_trig(t, N, 1'b0, 1'b0);
        localparam logic signed [DATA_W-1:0] IM = q15_trig(t, N, 1'b1, 1'b1);
        assign rom_w[t] = {RE, IM};
    end

    assign twi_o = rom_w[t_i];
endmodule

// File: rtl/fft_stage_feeder.sv
// Buffers one N-sample frame, then issues N/2 {even, odd, twiddle} triples for one DIT stage.
//   state    | meaning
//   ST_LOAD  | accepting samples into the frame buffer, n counts them
//   ST_ISSUE | emitting one operand triple per enabled cycle, k counts them
module fft_stage_feeder import fft_pkg::*; #(
    parameter int N      = 8,
    parameter int STAGE  = 0,
    parameter int BITREV = 1,
    parameter int I      = 1,
    parameter int F      = 15
) (
    input logic          i_clk,
    input logic          i_rst_n,
    input logic          i_en,
    fft_stage_feeder_if.slave bus
);
    localparam int AW  = addr_w(N);
    localparam int KW  = AW - 1;
    localparam int TSH = AW - 1 - STAGE;
    localparam logic [AW-1:0] SPAN = AW'(1) << STAGE;
    localparam logic [AW-1:0] MASK = SPAN - AW'(1);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    if (N < 4 || (N & (N - 1)) != 0 || STAGE < 0 || STAGE >= AW || I + F != DATA_W) begin : g_bad_cfg
        $error("fft_stage_feeder: unsupported parameter combination");
    end

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;
    logic          valid_q, valid_d, last_q, last_d;
    cplx_t         even_q, even_d, odd_q, odd_d, twi_q, twi_d;
    cplx_t         buf_q [N];

    logic [AW-1:0] k_ext, j_w, even_w, odd_w, wa_w;
    logic [KW-1:0] t_w;
    cplx_t         twi_w;
    logic          accept;

    twiddle_rom #(.N(N)) u_rom (.t_i(t_w), .twi_o(twi_w));

    assign bus.o_ready  = i_en && (state_q == ST_LOAD);
    assign accept       = bus.o_ready && bus.i_valid;
    assign bus.o_valid  = valid_q;
    assign bus.o_last   = last_q;
    assign bus.o_o_even = even_q;
    assign bus.o_o_odd  = odd_q;
    assign bus.o_o_twi  = twi_q;

    // Pairing addresses for triple k and the write address for sample n.
    always_comb begin
        k_ext  = {1'b0, k_q};
        j_w    = k_ext & MASK;
        even_w = ((k_ext >> STAGE) << (STAGE + 1)) | j_w;
        odd_w  = even_w | SPAN;
        t_w    = KW'(j_w << TSH);
        wa_w   = (BITREV != 0) ? AW'(bitrev(32'(n_q), AW)) : n_q;
    end

    // Next-state: everything holds unless enabled.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        valid_d = valid_q;
        last_d  = last_q;
        even_d  = even_q;
        odd_d   = odd_q;
        twi_d   = twi_q;
        if (i_en) begin
            case (state_q)
                ST_LOAD: begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (bus.i_valid) begin
                        if (n_q == AW'(N - 1)) begin
                            n_d     = '0;
                            state_d = ST_ISSUE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end
                end
                default: begin
                    valid_d = 1'b1;
                    even_d  = buf_q[even_w];
                    odd_d   = buf_q[odd_w];
                    twi_d   = twi_w;
                    last_d  = (k_q == KW'(N/2 - 1));
                    if (k_q == KW'(N/2 - 1)) begin
                        k_d     = '0;
                        state_d = ST_LOAD;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            n_q     <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            even_q  <= '0;
            odd_q   <= '0;
            twi_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            twi_q   <= twi_d;
        end
    end

    // Frame buffer; contents survive reset, a fresh frame overwrites every entry.
    always_ff @(posedge i_clk) begin
        if (accept) buf_q[wa_w] <= bus.i_i_data;
    end
endmodule

// File: tb/tb_fft_stage_feeder.sv
// Directed bench: three feeder configurations (N=8, stages 0/1/2) driven in lockstep.
module tb_fft_stage_feeder;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;

    always #5 clk = ~clk;

    fft_stage_feeder_if bus_a ();
    fft_stage_feeder_if bus_b ();
    fft_stage_feeder_if bus_c ();

    assign bus_a.i_valid = valid;  assign bus_a.i_i_data = data;
    assign bus_b.i_valid = valid;  assign bus_b.i_i_data = data;
    assign bus_c.i_valid = valid;  assign bus_c.i_i_data = data;

    fft_stage_feeder #(.N(8), .STAGE(0), .BITREV(1), .I(1), .F(15)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .bus(bus_a));
    fft_stage_feeder #(.N(8), .STAGE(1), .BITREV(0), .I(1), .F(15)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .bus(bus_b));
    fft_stage_feeder #(.N(8), .STAGE(2), .BITREV(0), .I(1), .F(15)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .bus(bus_c));

    typedef struct {
        int          cfg;
        int          k;
        logic [31:0] even;
        logic [31:0] odd;
        logic [31:0] twi;
        logic        last;
    } vec_t;

    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] e;
        logic [31:0] o;
        logic [31:0] t;
    } out_t;

    localparam logic [31:0] W0 = {16'h7FFF, 16'h0000};
    localparam logic [31:0] W1 = {16'h5A82, 16'hA57E};
    localparam logic [31:0] W2 = {16'h0000, 16'h8000};
    localparam logic [31:0] W3 = {16'hA57E, 16'hA57E};

    vec_t        tbl [12];
    logic [31:0] g_even [3][4];
    logic [31:0] g_odd  [3][4];
    logic [31:0] g_twi  [3][4];
    logic        g_last [3][4];
    int          nvec = 0;
    int          nerr = 0;
    int          rl;

    function automatic logic [31:0] xs(input int n);
        return {16'(n * 1024), 16'h0000};
    endfunction

    function automatic out_t sample(input int c);
        out_t s;
        case (c)
            0:       begin s.v = bus_a.o_valid; s.l = bus_a.o_last; s.e = bus_a.o_o_even; s.o = bus_a.o_o_odd; s.t = bus_a.o_o_twi; end
            1:       begin s.v = bus_b.o_valid; s.l = bus_b.o_last; s.e = bus_b.o_o_even; s.o = bus_b.o_o_odd; s.t = bus_b.o_o_twi; end
            default: begin s.v = bus_c.o_valid; s.l = bus_c.o_last; s.e = bus_c.o_o_even; s.o = bus_c.o_o_odd; s.t = bus_c.o_o_twi; end
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic set_row(input int i, input int c, input int k, input int e, input int o,
                           input logic [31:0] w, input logic l);
        tbl[i].cfg = c;  tbl[i].k = k;
        tbl[i].even = xs(e);  tbl[i].odd = xs(o);
        tbl[i].twi = w;  tbl[i].last = l;
    endtask

    task automatic load_frame(input bit toggle, input int nsamp);
        int n = 0;
        int guard = 0;
        bit acc;
        en = 1'b1;
        while (n < nsamp && guard < 64) begin
            valid = toggle ? (guard % 2 == 0) : 1'b1;
            data  = valid ? xs(n) : 32'hDEAD_BEEF;
            acc   = valid && bus_a.o_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) n++;
            chk("valid_low_in_load", 32'(bus_a.o_valid), 32'd0);
        end
        if (n < nsamp) begin
            nvec++; nerr++;
            $display("FAIL load_timeout: got %0d samples, expected %0d", n, nsamp);
        end else if (!toggle) begin
            chk("load_cycles", guard, nsamp);
        end
        valid = 1'b0;
    endtask

    task automatic capture(input int stall_after, input bit keep_valid, input int ntrip,
                           output int ready_low);
        int   cnt = 0;
        int   ecnt = 0;
        int   guard = 0;
        bit   stalled = 1'b0;
        out_t s;
        ready_low = 0;
        en    = 1'b1;
        valid = keep_valid;
        data  = 32'h5555_5555;
        while (cnt < ntrip && guard < 40) begin
            guard++;
            if (!stalled && cnt == stall_after) begin
                stalled = 1'b1;
                en = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    for (int c = 0; c < 3; c++) begin
                        s = sample(c);
                        chk("stall_valid", 32'(s.v), 32'd1);
                        chk("stall_last", 32'(s.l), 32'(tbl[c*4+cnt-1].last));
                        chk("stall_even", s.e, tbl[c*4+cnt-1].even);
                        chk("stall_odd", s.o, tbl[c*4+cnt-1].odd);
                        chk("stall_twi", s.t, tbl[c*4+cnt-1].twi);
                    end
                    chk("stall_ready", 32'(bus_a.o_ready), 32'd0);
                end
                en = 1'b1;
            end
            if (!bus_a.o_ready) ready_low++;
            @(posedge clk); #1;
            ecnt++;
            if (bus_a.o_valid) begin
                chk("triple_timing", ecnt, cnt + 1);
                for (int c = 0; c < 3; c++) begin
                    s = sample(c);
                    if (c > 0) chk("valid_lockstep", 32'(s.v), 32'd1);
                    g_even[c][cnt] = s.e;
                    g_odd[c][cnt]  = s.o;
                    g_twi[c][cnt]  = s.t;
                    g_last[c][cnt] = s.l;
                end
                cnt++;
            end
        end
        if (cnt < ntrip) begin
            nvec++; nerr++;
            $display("FAIL issue_timeout: got %0d triples, expected %0d", cnt, ntrip);
        end else if (ntrip == 4) begin
            chk("ready_after_last", 32'(bus_a.o_ready), 32'd1);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 12; i++) begin
            int c = tbl[i].cfg;
            int k = tbl[i].k;
            chk($sformatf("%s_c%0d_k%0d_even", tag, c, k), g_even[c][k], tbl[i].even);
            chk($sformatf("%s_c%0d_k%0d_odd", tag, c, k), g_odd[c][k], tbl[i].odd);
            chk($sformatf("%s_c%0d_k%0d_twi", tag, c, k), g_twi[c][k], tbl[i].twi);
            chk($sformatf("%s_c%0d_k%0d_last", tag, c, k), 32'(g_last[c][k]), 32'(tbl[i].last));
        end
    endtask

    task automatic check_zero(input string tag);
        out_t s;
        for (int c = 0; c < 3; c++) begin
            s = sample(c);
            chk({tag, "_valid"}, 32'(s.v), 32'd0);
            chk({tag, "_last"}, 32'(s.l), 32'd0);
            chk({tag, "_even"}, s.e, 32'd0);
            chk({tag, "_odd"}, s.o, 32'd0);
            chk({tag, "_twi"}, s.t, 32'd0);
        end
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #2;
        check_zero(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(bus_a.o_ready), 32'd1);
    endtask

    initial begin
        set_row(0,  0, 0, 0, 4, W0, 1'b0);
        set_row(1,  0, 1, 2, 6, W0, 1'b0);
        set_row(2,  0, 2, 1, 5, W0, 1'b0);
        set_row(3,  0, 3, 3, 7, W0, 1'b1);
        set_row(4,  1, 0, 0, 2, W0, 1'b0);
        set_row(5,  1, 1, 1, 3, W2, 1'b0);
        set_row(6,  1, 2, 4, 6, W0, 1'b0);
        set_row(7,  1, 3, 5, 7, W2, 1'b1);
        set_row(8,  2, 0, 0, 4, W0, 1'b0);
        set_row(9,  2, 1, 1, 5, W1, 1'b0);
        set_row(10, 2, 2, 2, 6, W2, 1'b0);
        set_row(11, 2, 3, 3, 7, W3, 1'b1);

        en = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_zero("reset");
        chk("reset_ready", 32'(bus_a.o_ready), 32'd1);

        load_frame(1'b0, 8);
        capture(99, 1'b0, 4, rl);
        check_frame("plain");

        load_frame(1'b1, 8);
        capture(2, 1'b0, 4, rl);
        check_frame("stall");

        load_frame(1'b0, 5);
        reset_pulse("rst_load");
        load_frame(1'b0, 8);
        capture(99, 1'b0, 2, rl);
        reset_pulse("rst_issue");
        load_frame(1'b0, 8);
        capture(99, 1'b0, 4, rl);
        check_frame("after_rst");

        load_frame(1'b0, 8);
        capture(99, 1'b1, 4, rl);
        chk("ready_low_frame1", rl, 4);
        load_frame(1'b0, 8);
        capture(99, 1'b1, 4, rl);
        chk("ready_low_frame2", rl, 4);
        check_frame("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
